pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the RV32I core: arbitrates stall requests from execute, bus interconnect and JTAG, merges execute jumps with CLINT interrupt redirects, and drives the `pc`/`if_id`/`id_ex` hold and jump inputs. It owns a post-redirect fetch-flush counter and a JTAG halt/drain state machine. It sits between `ex`/`clint`/`rib`/`jtag` and the PC and pipeline registers.

## Interface
- `FLUSH_DEPTH`, 1 — cycles of `Hold_If` after each redirect; 0..7.
- `clk` in 1 — core clock.
- `rst` in 1 — synchronous reset, active-low.
- `jump_flag_i` in 1 — execute requests redirect.
- `jump_addr_i` in 32 (`InstAddrBus`) — execute redirect target.
- `int_assert_i` in 1 — CLINT requests interrupt redirect.
- `int_addr_i` in 32 — CLINT redirect target.
- `hold_flag_ex_i` in 1 — execute multi-cycle stall, e.g. divider.
- `hold_flag_rib_i` in 1 — bus busy, freeze PC only.
- `jtag_halt_flag_i` in 1 — debugger halt request, level.
- `hold_flag_o` out 3 (`Hold_Flag_Bus`) — stage hold level.
- `jump_flag_o` out 1 — redirect to PC.
- `jump_addr_o` out 32 — redirect target.
- `halted_o` out 1 — core quiescent and halted.

## Operation
- Hold encoding: `Hold_None`=0, `Hold_Pc`=1, `Hold_If`=2, `Hold_Id`=3. `hold_flag_o` is the maximum over all active sources.
- Sources: redirect cycle → `Hold_Id`; `hold_flag_ex_i` → `Hold_Id`; flush counter nonzero → `Hold_If`; `hold_flag_rib_i` → `Hold_Pc`; state DRAIN or HALTED → `Hold_Id`; `rst` low → `Hold_Id`.
- Redirect priority: `int_assert_i` first, then `jump_flag_i`. `jump_addr_o` takes the winner's address. With no redirect, `jump_addr_o` is 0.
- `int_assert_i` is masked in HALTED. CLINT must keep it pending.
- `jump_flag_i` is honoured in every state.
- Flush counter: loads `FLUSH_DEPTH` on every redirect cycle, including a redirect during a flush, which restarts it. Otherwise it decrements to 0 and saturates there. With `FLUSH_DEPTH`=0 there is no flush.
- FSM states: RUN, DRAIN, HALTED.
  - RUN → DRAIN when `jtag_halt_flag_i`=1.
  - DRAIN → HALTED when, in the same cycle, there is no redirect, `hold_flag_ex_i`=0, `hold_flag_rib_i`=0 and the flush counter is 0.
  - DRAIN → RUN if `jtag_halt_flag_i` drops.
  - HALTED → RUN when `jtag_halt_flag_i`=0.
- `halted_o`=1 only in HALTED.

## Timing
- `hold_flag_o`, `jump_flag_o` and `jump_addr_o` are combinational from the inputs and registered state, with zero latency. The PC consumes them at the next edge.
- The FSM and flush counter update on `posedge clk`.
- Reset (`rst`=0 at the edge): state RUN, counter 0.
- While `rst`=0: `hold_flag_o`=3, `jump_flag_o`=0, `jump_addr_o`=0, `halted_o`=0. This holds even if `jtag_halt_flag_i` or `int_assert_i` is high.
- Reset mid-DRAIN or mid-flush: both are abandoned, and the core returns to RUN with counter 0 next cycle.
- Redirect cycle N: `hold_flag_o`=3. Cycles N+1..N+`FLUSH_DEPTH`: at least 2.
- Halt latency: entry to HALTED is the edge after the first quiescent DRAIN cycle (minimum 2 cycles after the request). Release to RUN takes 1 cycle.

## Configuration
- `PIPE_CTRL_JTAG_HALT_EN` defined: DRAIN/HALTED behaviour as above.
- Not defined: `jtag_halt_flag_i` is ignored, the FSM stays in RUN, and `halted_o` is tied 0. Ports are unchanged.

## Structure
- Shared defines: `Hold_None`/`Hold_Pc`/`Hold_If`/`Hold_Id`, `Hold_Flag_Bus`, `InstAddrBus`, `ZeroWord`. State encodings stay local.
- One sub-module, `pipe_ctrl_flush_cnt`: load/decrement/saturate counter with a `busy_o` output.

## Test plan
- Reset: hold `rst`=0 with `int_assert_i`=1 → `hold_flag_o`=3, `jump_flag_o`=0; on release, `hold_flag_o`=0.
- Simultaneous redirects: `jump_flag_i`=1 @0x100 and `int_assert_i`=1 @0x8 in the same cycle → `jump_addr_o`=0x8, `hold_flag_o`=3; next cycle `hold_flag_o`=2.
- Flush restart: with `FLUSH_DEPTH`=3, jump at cycle 0, second jump at cycle 2 → `Hold_If` through cycle 5, `hold_flag_o`=0 at cycle 6.
- Hold merge: `hold_flag_rib_i`=1 alone → 1; `hold_flag_rib_i` with flush active → 2; `hold_flag_rib_i` with `hold_flag_ex_i` → 3.
- Halt drain: `jtag_halt_flag_i`=1 while `hold_flag_ex_i`=1 for 4 cycles → `halted_o` rises 1 cycle after ex releases; `int_assert_i` while halted → `jump_flag_o`=0; halt drops → RUN, `halted_o`=0 next cycle.
- Macro off: `jtag_halt_flag_i`=1 → `halted_o`=0 and `hold_flag_o`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared hold-level encodings, bus widths and constants for the RV32I pipeline control slice.
package pipe_ctrl_pkg;

  localparam int HoldFlagBusW = 3;
  localparam int InstAddrBusW = 32;

  typedef logic [HoldFlagBusW-1:0] Hold_Flag_Bus;
  typedef logic [InstAddrBusW-1:0] InstAddrBus;

  localparam Hold_Flag_Bus Hold_None = 3'd0;
  localparam Hold_Flag_Bus Hold_Pc   = 3'd1;
  localparam Hold_Flag_Bus Hold_If   = 3'd2;
  localparam Hold_Flag_Bus Hold_Id   = 3'd3;

  localparam InstAddrBus ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_flush_cnt.sv
// Post-redirect fetch-flush counter: loads FLUSH_DEPTH on a redirect, then counts down to 0 and saturates.
module pipe_ctrl_flush_cnt #(
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic busy_o
);

  localparam logic [2:0] DepthC = 3'(FLUSH_DEPTH);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = DepthC;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 3'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, redirect merge, fetch flush and JTAG halt/drain.
// Define PIPE_CTRL_JTAG_HALT_EN to enable the DRAIN/HALTED debugger states.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jump_flag_i,
  input  logic [InstAddrBusW-1:0] jump_addr_i,
  input  logic                    int_assert_i,
  input  logic [InstAddrBusW-1:0] int_addr_i,
  input  logic                    hold_flag_ex_i,
  input  logic                    hold_flag_rib_i,
  input  logic                    jtag_halt_flag_i,
  output logic [HoldFlagBusW-1:0] hold_flag_o,
  output logic                    jump_flag_o,
  output logic [InstAddrBusW-1:0] jump_addr_o,
  output logic                    halted_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic int_ok_s;
  logic redirect_s;
  logic flush_busy_s;
  logic hold_id_s;

  // CLINT stays pending while halted; only execute jumps get through.
  assign int_ok_s   = int_assert_i && (state_q != ST_HALTED);
  assign redirect_s = rst && (int_ok_s || jump_flag_i);
  assign hold_id_s  = redirect_s || hold_flag_ex_i || (state_q != ST_RUN);

  pipe_ctrl_flush_cnt #(
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(redirect_s),
    .busy_o(flush_busy_s)
  );

  always_comb begin
    hold_flag_o = Hold_None;
    if (!rst || hold_id_s) begin
      hold_flag_o = Hold_Id;
    end else if (flush_busy_s) begin
      hold_flag_o = Hold_If;
    end else if (hold_flag_rib_i) begin
      hold_flag_o = Hold_Pc;
    end else begin
      hold_flag_o = Hold_None;
    end
  end

  always_comb begin
    jump_addr_o = ZeroWord;
    if (!rst) begin
      jump_addr_o = ZeroWord;
    end else if (int_ok_s) begin
      jump_addr_o = int_addr_i;
    end else if (jump_flag_i) begin
      jump_addr_o = jump_addr_i;
    end else begin
      jump_addr_o = ZeroWord;
    end
  end

  assign jump_flag_o = redirect_s;

`ifdef PIPE_CTRL_JTAG_HALT_EN
  logic quiescent_s;
  assign quiescent_s = !redirect_s && !hold_flag_ex_i && !hold_flag_rib_i && !flush_busy_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (jtag_halt_flag_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!jtag_halt_flag_i) begin
          state_d = ST_RUN;
        end else if (quiescent_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (!jtag_halt_flag_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign halted_o = rst && (state_q == ST_HALTED);
`else
  logic jtag_unused_s;
  assign jtag_unused_s = jtag_halt_flag_i;
  assign state_d       = ST_RUN;
  assign halted_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_DEPTH=3); halt checks follow PIPE_CTRL_JTAG_HALT_EN.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_flag_rib_i;
  logic        jtag_halt_flag_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        halted_o;

  int total;
  int bad;

  pipe_ctrl #(
    .FLUSH_DEPTH(3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .int_assert_i    (int_assert_i),
    .int_addr_i      (int_addr_i),
    .hold_flag_ex_i  (hold_flag_ex_i),
    .hold_flag_rib_i (hold_flag_rib_i),
    .jtag_halt_flag_i(jtag_halt_flag_i),
    .hold_flag_o     (hold_flag_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .halted_o        (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0; int_assert_i = 1'b1;
    int_addr_i = 32'h8; hold_flag_ex_i = 1'b0; hold_flag_rib_i = 1'b0; jtag_halt_flag_i = 1'b1;

    // reset dominates pending interrupt and halt request
    #2;
    chk("rst_hold", 32'(hold_flag_o), 32'd3);
    chk("rst_jf", 32'(jump_flag_o), 32'd0);
    chk("rst_addr", jump_addr_o, 32'h0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    cyc(); cyc(); #1;
    chk("rst_hold2", 32'(hold_flag_o), 32'd3);
    chk("rst_jf2", 32'(jump_flag_o), 32'd0);
    cyc();
    rst = 1'b1; int_assert_i = 1'b0; jtag_halt_flag_i = 1'b0; #1;
    chk("rel_hold", 32'(hold_flag_o), 32'd0);
    chk("rel_jf", 32'(jump_flag_o), 32'd0);

    // simultaneous redirects: interrupt wins
    cyc();
    jump_flag_i = 1'b1; jump_addr_i = 32'h100; int_assert_i = 1'b1; int_addr_i = 32'h8; #1;
    chk("sim_addr", jump_addr_o, 32'h8);
    chk("sim_jf", 32'(jump_flag_o), 32'd1);
    chk("sim_hold", 32'(hold_flag_o), 32'd3);
    cyc();
    jump_flag_i = 1'b0; int_assert_i = 1'b0; #1;
    chk("sim_hold_n1", 32'(hold_flag_o), 32'd2);
    chk("sim_jf_n1", 32'(jump_flag_o), 32'd0);
    chk("sim_addr_n1", jump_addr_o, 32'h0);
    cyc(); cyc(); cyc(); #1;
    chk("sim_flush_end", 32'(hold_flag_o), 32'd0);

    // flush restart: jumps at cycles 0 and 2
    cyc();
    jump_flag_i = 1'b1; jump_addr_i = 32'h100; #1;
    chk("fr_c0_addr", jump_addr_o, 32'h100);
    chk("fr_c0_hold", 32'(hold_flag_o), 32'd3);
    cyc();
    jump_flag_i = 1'b0; #1;
    chk("fr_c1_hold", 32'(hold_flag_o), 32'd2);
    cyc();
    jump_flag_i = 1'b1; jump_addr_i = 32'h200; #1;
    chk("fr_c2_hold", 32'(hold_flag_o), 32'd3);
    chk("fr_c2_addr", jump_addr_o, 32'h200);
    cyc();
    jump_flag_i = 1'b0; #1;
    chk("fr_c3_hold", 32'(hold_flag_o), 32'd2);
    for (int i = 4; i < 6; i++) begin
      cyc(); #1;
      chk("fr_c45_hold", 32'(hold_flag_o), 32'd2);
    end
    cyc(); #1;
    chk("fr_c6_hold", 32'(hold_flag_o), 32'd0);

    // hold merge
    hold_flag_rib_i = 1'b1; #1;
    chk("hm_rib", 32'(hold_flag_o), 32'd1);
    cyc();
    jump_flag_i = 1'b1; jump_addr_i = 32'h40; #1;
    chk("hm_jump", 32'(hold_flag_o), 32'd3);
    cyc();
    jump_flag_i = 1'b0; #1;
    chk("hm_rib_flush", 32'(hold_flag_o), 32'd2);
    cyc(); cyc(); cyc(); #1;
    chk("hm_rib_after", 32'(hold_flag_o), 32'd1);
    hold_flag_ex_i = 1'b1; #1;
    chk("hm_rib_ex", 32'(hold_flag_o), 32'd3);
    cyc();
    hold_flag_ex_i = 1'b0; hold_flag_rib_i = 1'b0; #1;
    chk("hm_clear", 32'(hold_flag_o), 32'd0);

    // reset mid-flush clears the counter
    cyc();
    jump_flag_i = 1'b1; #1;
    cyc();
    jump_flag_i = 1'b0; rst = 1'b0; #1;
    chk("rmf_hold", 32'(hold_flag_o), 32'd3);
    cyc();
    rst = 1'b1; #1;
    chk("rmf_after", 32'(hold_flag_o), 32'd0);

`ifdef PIPE_CTRL_JTAG_HALT_EN
    // halt with execute stalled for 4 cycles
    cyc();
    jtag_halt_flag_i = 1'b1; hold_flag_ex_i = 1'b1; #1;
    chk("hd_c0_halted", 32'(halted_o), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(); #1;
      chk("hd_drain_halted", 32'(halted_o), 32'd0);
      chk("hd_drain_hold", 32'(hold_flag_o), 32'd3);
    end
    cyc();
    hold_flag_ex_i = 1'b0; #1;
    chk("hd_c4_halted", 32'(halted_o), 32'd0);
    chk("hd_c4_hold", 32'(hold_flag_o), 32'd3);
    cyc(); #1;
    chk("hd_c5_halted", 32'(halted_o), 32'd1);
    int_assert_i = 1'b1; int_addr_i = 32'h8; #1;
    chk("hd_int_masked", 32'(jump_flag_o), 32'd0);
    chk("hd_int_addr", jump_addr_o, 32'h0);
    chk("hd_int_hold", 32'(hold_flag_o), 32'd3);
    cyc();
    int_assert_i = 1'b0; jump_flag_i = 1'b1; jump_addr_i = 32'h300; #1;
    chk("hd_jump_jf", 32'(jump_flag_o), 32'd1);
    chk("hd_jump_addr", jump_addr_o, 32'h300);
    cyc();
    jump_flag_i = 1'b0; #1;
    chk("hd_still", 32'(halted_o), 32'd1);
    cyc(); cyc(); cyc();
    jtag_halt_flag_i = 1'b0; #1;
    chk("hd_rel_same", 32'(halted_o), 32'd1);
    cyc(); #1;
    chk("hd_rel_halted", 32'(halted_o), 32'd0);
    chk("hd_rel_hold", 32'(hold_flag_o), 32'd0);

    // DRAIN abandoned when halt drops
    jtag_halt_flag_i = 1'b1; hold_flag_ex_i = 1'b1;
    cyc();
    jtag_halt_flag_i = 1'b0; hold_flag_ex_i = 1'b0; #1;
    chk("da_hold", 32'(hold_flag_o), 32'd3);
    cyc(); #1;
    chk("da_run_hold", 32'(hold_flag_o), 32'd0);
    chk("da_run_halted", 32'(halted_o), 32'd0);

    // reset mid-DRAIN
    jtag_halt_flag_i = 1'b1; hold_flag_ex_i = 1'b1;
    cyc();
    rst = 1'b0; #1;
    chk("rmd_halted", 32'(halted_o), 32'd0);
    cyc();
    rst = 1'b1; jtag_halt_flag_i = 1'b0; hold_flag_ex_i = 1'b0; #1;
    chk("rmd_hold", 32'(hold_flag_o), 32'd0);
`else
    // halt request ignored
    cyc();
    jtag_halt_flag_i = 1'b1; #1;
    chk("mo_hold0", 32'(hold_flag_o), 32'd0);
    cyc(); cyc(); cyc(); #1;
    chk("mo_halted", 32'(halted_o), 32'd0);
    chk("mo_hold", 32'(hold_flag_o), 32'd0);
    jtag_halt_flag_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
